// File: rtl/mem_access.sv
// mem_access: data-memory stage of the sequential Y86-64 core.
// Performs the 8-byte little-endian access for rmmovq, mrmovq, pushq, popq,
// call and ret against an internal byte-wide RAM, one byte per clock.
// Optional feature: define MEM_BOUNDS_CHECK_EN to fault any access whose
// eight bytes do not fit below DEPTH. Without it, addresses wrap modulo DEPTH
// and mem_error stays low.
module mem_access #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic [63:0] valM,
  output logic        busy,
  output logic        done,
  output logic        mem_error
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t          state_q;
  logic [2:0]      cnt_q;
  logic [AW-1:0]   addr_q;
  logic [63:0]     wdata_q;
  logic [55:0]     rdata_q;
  logic            isWrite_q;
  logic [63:0]     valM_q;
  logic            busy_q;
  logic            done_q;
  logic            memError_q;

  logic [7:0]      ram_q [DEPTH];

  logic [63:0]     reqAddr;
  logic [63:0]     reqData;
  logic            reqIsMem;
  logic            reqIsWrite;
  logic            reqFault;
  logic [AW-1:0]   byteIdx;
  logic [7:0]      rdByte;

  // Decode the incoming icode into access kind, address source and write data.
  always_comb begin
    reqAddr    = valE;
    reqData    = valA;
    reqIsMem   = 1'b0;
    reqIsWrite = 1'b0;
    case (icode)
      4'h4: begin
        reqIsMem   = 1'b1;
        reqIsWrite = 1'b1;
      end
      4'hA: begin
        reqIsMem   = 1'b1;
        reqIsWrite = 1'b1;
      end
      4'h8: begin
        reqIsMem   = 1'b1;
        reqIsWrite = 1'b1;
        reqData    = valP;
      end
      4'h5: begin
        reqIsMem = 1'b1;
      end
      4'hB: begin
        reqIsMem = 1'b1;
        reqAddr  = valA;
      end
      4'h9: begin
        reqIsMem = 1'b1;
        reqAddr  = valA;
      end
      default: begin
        reqIsMem = 1'b0;
      end
    endcase
  end

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [63:0] LAST_OK = 64'(DEPTH - 8);
  // The full 64-bit address is compared, so an access that would spill past
  // the top of memory (or past 2^64) is a fault rather than a wrap.
  assign reqFault = reqAddr > LAST_OK;
`else
  logic unusedAddrHi;
  assign reqFault     = 1'b0;
  assign unusedAddrHi = ^reqAddr[63:AW];
`endif

  // Only the low address bits are kept; in-range addresses never carry out of
  // them, and without the bounds check the carry-drop is the intended wrap.
  assign byteIdx = addr_q + AW'(cnt_q);
  assign rdByte  = ram_q[byteIdx];

  // Byte-wide RAM write port; deliberately not reset so a partial word
  // survives a mid-access reset.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && isWrite_q) begin
      ram_q[byteIdx] <= wdata_q[7:0];
    end
  end

  // Sequencing FSM with registered handshake outputs and read assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 64'd0;
      rdata_q    <= 56'd0;
      isWrite_q  <= 1'b0;
      valM_q     <= 64'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      memError_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (!reqIsMem) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              valM_q     <= 64'd0;
              memError_q <= 1'b0;
            end else if (reqFault) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              valM_q     <= 64'd0;
              memError_q <= 1'b1;
            end else begin
              state_q   <= ACCESS;
              cnt_q     <= 3'd0;
              addr_q    <= reqAddr[AW-1:0];
              wdata_q   <= reqData;
              isWrite_q <= reqIsWrite;
              rdata_q   <= 56'd0;
            end
          end
        end
        ACCESS: begin
          cnt_q   <= cnt_q + 3'd1;
          wdata_q <= {8'd0, wdata_q[63:8]};
          rdata_q <= {rdByte, rdata_q[55:8]};
          if (cnt_q == 3'd7) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            valM_q     <= isWrite_q ? 64'd0 : {rdByte, rdata_q};
            memError_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valM      = valM_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_error = memError_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed bench for mem_access with a transaction-level
// reference model and a per-cycle compare process.
module tb_mem_access;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic [63:0] valM;
  logic        busy;
  logic        done;
  logic        mem_error;

  int checks = 0;
  int errors = 0;

  mem_access #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .icode     (icode),
    .valE      (valE),
    .valA      (valA),
    .valP      (valP),
    .valM      (valM),
    .busy      (busy),
    .done      (done),
    .mem_error (mem_error)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: one outstanding request, described by its
  // acceptance edge and latency, plus a byte-array image of memory.
  logic [7:0]  modelMem [DEPTH];
  int          edgeCnt   = 0;
  bit          active    = 0;
  int          accEdge   = 0;
  int          lat       = 0;
  bit          committed = 0;
  bit          pendWrite = 0;
  logic [63:0] pendAddr  = 0;
  logic [63:0] pendData  = 0;
  logic [63:0] pendValM  = 0;
  bit          pendErr   = 0;
  logic [63:0] expValM   = 0;
  bit          valMKnown = 1;
  bit          expErr    = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelCommit(input int nBytes);
    for (int j = 0; j < nBytes; j++) begin
      modelMem[int'((pendAddr + 64'(j)) % 64'(DEPTH))] = pendData[8*j +: 8];
    end
  endtask

  // Model: accept requests when idle, retire them when done is due.
  always @(posedge clk) begin
    if (rst_n) begin
      edgeCnt++;
      if (start && (!active || edgeCnt >= accEdge + lat + 1)) begin
        logic [63:0] a;
        logic [63:0] d;
        bit          isMem;
        bit          isWr;
        bit          fault;
        a = valE; d = valA; isMem = 1; isWr = 0;
        case (icode)
          4'h4, 4'hA: isWr = 1;
          4'h8: begin isWr = 1; d = valP; end
          4'h5: ;
          4'h9, 4'hB: a = valA;
          default: isMem = 0;
        endcase
`ifdef MEM_BOUNDS_CHECK_EN
        fault = isMem && (a > 64'(DEPTH - 8));
`else
        fault = 0;
`endif
        active    = 1;
        accEdge   = edgeCnt;
        committed = 0;
        lat       = (isMem && !fault) ? 9 : 1;
        pendWrite = isMem && !fault && isWr;
        pendAddr  = a;
        pendData  = d;
        pendErr   = fault;
        pendValM  = 0;
        if (isMem && !fault && !isWr) begin
          for (int j = 0; j < 8; j++) begin
            pendValM[8*j +: 8] = modelMem[int'((a + 64'(j)) % 64'(DEPTH))];
          end
        end
      end
      if (active && !committed && edgeCnt == accEdge + lat - 1) begin
        if (pendWrite) modelCommit(8);
        committed = 1;
        expValM   = pendValM;
        valMKnown = !pendWrite;
        expErr    = pendErr;
      end
    end
  end

  // Compare every DUT output against the model once per cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      bit expBusy;
      bit expDone;
      expBusy = active && edgeCnt >= accEdge && edgeCnt <= accEdge + lat - 1;
      expDone = active && edgeCnt == accEdge + lat - 1;
      checkOutput("busy", {63'd0, busy}, {63'd0, expBusy});
      checkOutput("done", {63'd0, done}, {63'd0, expDone});
      checkOutput("mem_error", {63'd0, mem_error}, {63'd0, expErr});
      if (valMKnown) checkOutput("valM", valM, expValM);
    end
  end

  task automatic applyStimulus(input logic [3:0] ic, input logic [63:0] e,
                               input logic [63:0] a, input logic [63:0] p);
    @(posedge clk);
    #2;
    icode = ic; valE = e; valA = a; valP = p;
    start = 1'b1;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done || n >= 30) break;
    end
  endtask

  task automatic runReq(input string name, input logic [3:0] ic, input logic [63:0] e,
                        input logic [63:0] a, input logic [63:0] p, input int expLat);
    int n;
    applyStimulus(ic, e, a, p);
    waitDone(n);
    checkOutput(name, 64'(n), 64'(expLat));
  endtask

  task automatic assertReset();
    rst_n = 1'b0;
    if (active && !committed && pendWrite) begin
      int nb;
      nb = edgeCnt - accEdge;
      if (nb > 8) nb = 8;
      if (nb < 0) nb = 0;
      modelCommit(nb);
    end
    active    = 0;
    expValM   = 0;
    valMKnown = 1;
    expErr    = 0;
    #1;
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset done", {63'd0, done}, 64'd0);
    checkOutput("reset valM", valM, 64'd0);
    checkOutput("reset mem_error", {63'd0, mem_error}, 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    icode = 4'h0; valE = 64'd0; valA = 64'd0; valP = 64'd0;
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    assertReset();

    runReq("rmmovq latency", 4'h4, 64'h10, 64'h1122334455667788, 64'd0, 9);
    runReq("mrmovq latency", 4'h5, 64'h10, 64'd0, 64'd0, 9);
    checkOutput("mrmovq data", valM, 64'h1122334455667788);
    checkOutput("ram byte 0x10", {56'd0, dut.ram_q[16]}, 64'h88);

    runReq("call latency", 4'h8, 64'h3F8, 64'd0, 64'h40, 9);
    runReq("ret latency", 4'h9, 64'd0, 64'h3F8, 64'd0, 9);
    checkOutput("ret data", valM, 64'h40);

    runReq("pushq latency", 4'hA, 64'h200, 64'hDEADBEEFCAFEF00D, 64'd0, 9);
    runReq("popq latency", 4'hB, 64'd0, 64'h200, 64'd0, 9);
    checkOutput("popq data", valM, 64'hDEADBEEFCAFEF00D);

    runReq("nonmem latency", 4'h6, 64'h10, 64'h55, 64'h66, 1);
    checkOutput("nonmem valM", valM, 64'd0);
    checkOutput("nonmem mem_error", {63'd0, mem_error}, 64'd0);

`ifdef MEM_BOUNDS_CHECK_EN
    runReq("fault latency", 4'h4, 64'h3F9, 64'h0807060504030201, 64'd0, 1);
    checkOutput("fault mem_error", {63'd0, mem_error}, 64'd1);
    checkOutput("fault ram 0x3F9", {56'd0, dut.ram_q[10'h3F9]}, 64'h00);
    runReq("huge addr latency", 4'h5, 64'hFFFFFFFFFFFFFFFC, 64'd0, 64'd0, 1);
    checkOutput("huge addr mem_error", {63'd0, mem_error}, 64'd1);
`else
    runReq("wrap latency", 4'h4, 64'h3F9, 64'h0807060504030201, 64'd0, 9);
    checkOutput("wrap mem_error", {63'd0, mem_error}, 64'd0);
    checkOutput("wrap ram 0x3FF", {56'd0, dut.ram_q[10'h3FF]}, 64'h07);
    checkOutput("wrap ram 0x000", {56'd0, dut.ram_q[0]}, 64'h08);
`endif
    runReq("reread latency", 4'h5, 64'h3F8, 64'd0, 64'd0, 9);

    // A start pulse during an access must be dropped entirely.
    applyStimulus(4'h5, 64'h10, 64'd0, 64'd0);
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    start = 1'b1; icode = 4'h5; valE = 64'h3F8; valA = 64'h3F8;
    @(posedge clk);
    #2;
    start = 1'b0;
    waitDone(n);
    checkOutput("ignored start done seen", {63'd0, done}, 64'd1);
    checkOutput("ignored start data", valM, 64'h1122334455667788);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no second done", {63'd0, done}, 64'd0);

    // Reset three bytes into an all-ones write over a zeroed word.
    runReq("zero latency", 4'h4, 64'h100, 64'd0, 64'd0, 9);
    applyStimulus(4'h4, 64'h100, 64'hFFFFFFFFFFFFFFFF, 64'd0);
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    assertReset();
    runReq("partial read latency", 4'h5, 64'h100, 64'd0, 64'd0, 9);
    checkOutput("partial word", valM, 64'h0000000000FFFFFF);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
